// File: rtl/mem_arbiter.sv
// Shares one single-ported fixed-latency memory between the fetch and data ports.
// One access in flight; data port preferred, alternating on contention so fetch is never starved.
module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [15:0] if_data,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       last_d, cancel;
  logic       elig_i, elig_d, grant_i, grant_d, last_cyc;

  // A port is ignored during its own done cycle so a still-high request is not reissued.
  always_comb begin
    elig_i   = if_req & ~if_done;
    elig_d   = dm_req & ~dm_done;
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    if (state == IDLE) begin
      grant_d = elig_d & (~elig_i | ~last_d);
      grant_i = elig_i & ~grant_d;
    end
    last_cyc = (state != IDLE) && (cnt == 4'd1);
    state_nx = state;
    if (grant_d)       state_nx = BUSY_D;
    else if (grant_i)  state_nx = BUSY_I;
    else if (last_cyc) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      last_d    <= 1'b0;
      cancel    <= 1'b0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_data   <= 16'h0000;
      dm_rdata  <= 16'h0000;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
    end else begin
      mem_en  <= grant_i | grant_d;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (grant_i | grant_d) begin
        cnt      <= 4'(LATENCY);
        mem_addr <= grant_d ? dm_addr : if_addr;
        mem_wr   <= grant_d & dm_wr;
        if (grant_d) mem_wdata <= dm_wdata;
        last_d   <= grant_d;
        cancel   <= grant_i & if_flush;
      end else if (state != IDLE) begin
        cnt <= cnt - 4'd1;
        if (state == BUSY_I && !last_cyc && if_flush) cancel <= 1'b1;
        if (last_cyc) begin
          cancel <= 1'b0;
          // A redirect seen in the final busy cycle also kills the fetch result.
          if (state == BUSY_I && !(cancel | if_flush)) begin
            if_done <= 1'b1;
            if_data <= mem_rdata;
          end
          if (state == BUSY_D) begin
            dm_done <= 1'b1;
            if (!mem_wr) dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

endmodule
